// File: rtl/arp_parser_rx.sv
// ARP receive parser (GMII RX domain).
// Walks the Ethernet header and the 28-byte ARP payload one byte per cycle.
// Every fixed field is checked, and frames are filtered on destination MAC and TPA.
// At end of frame it publishes opcode, SHA, SPA and source MAC for accepted frames.
module arp_parser_rx #(
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter logic [31:0] LOCAL_IP     = 32'hC0_A8_01_0A,
   parameter int          ACCEPT_REPLY = 1,
   parameter int          MIN_LEN      = 64,
   parameter int          CNT_W        = 16
) (
   input  logic             mac_gmii_rx_clk,
   input  logic             mac_gmii_rx_rst,
   input  logic [7:0]       mac_gmii_rxd,
   input  logic             mac_gmii_rx_dv,
   input  logic             mac_gmii_rx_er,
   input  logic             preamble_sfd_valid,
   output logic             arp_valid,
   output logic [15:0]      arp_oper,
   output logic [47:0]      arp_sha,
   output logic [31:0]      arp_spa,
   output logic [47:0]      arp_src_mac,
   output logic [CNT_W-1:0] cnt_accept,
   output logic [CNT_W-1:0] cnt_drop
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_ARP  = 3'd2;
   localparam logic [2:0] S_TAIL = 3'd3;
   localparam logic [2:0] S_IGN  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [10:0]      idx_q, idx_d;      // index of the byte currently on rxd
   logic             bad_q, bad_d;
   logic             bcast_q, bcast_d;  // dst MAC still matches FF..FF
   logic             ucast_q, ucast_d;  // dst MAC still matches LOCAL_MAC
   logic [7:0]       eth_hi_q, eth_hi_d;
   logic [47:0]      src_q, src_d;
   logic [15:0]      oper_q, oper_d;
   logic [47:0]      sha_q, sha_d;
   logic [31:0]      spa_q, spa_d;
   logic [31:0]      tpa_q, tpa_d;
   logic             arp_valid_q, arp_valid_d;
   logic [15:0]      arp_oper_q, arp_oper_d;
   logic [47:0]      arp_sha_q, arp_sha_d;
   logic [31:0]      arp_spa_q, arp_spa_d;
   logic [47:0]      arp_src_mac_q, arp_src_mac_d;
   logic [CNT_W-1:0] cnt_accept_q, cnt_accept_d;
   logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

   logic [10:0] idx_inc;
   logic        oper_ok;
   logic        frame_ok;

   // Byte i (0 = MSB) of the station MAC.
   function automatic logic [7:0] mac_byte(input logic [2:0] i);
      case (i)
         3'd0:    mac_byte = LOCAL_MAC[47:40];
         3'd1:    mac_byte = LOCAL_MAC[39:32];
         3'd2:    mac_byte = LOCAL_MAC[31:24];
         3'd3:    mac_byte = LOCAL_MAC[23:16];
         3'd4:    mac_byte = LOCAL_MAC[15:8];
         default: mac_byte = LOCAL_MAC[7:0];
      endcase
   endfunction

   // Required value of the fixed ARP bytes 14..19 (HTYPE, PTYPE, HLEN, PLEN).
   function automatic logic [7:0] fixed_byte(input logic [10:0] i);
      case (i)
         11'd15:  fixed_byte = 8'h01;
         11'd16:  fixed_byte = 8'h08;
         11'd18:  fixed_byte = 8'h06;
         11'd19:  fixed_byte = 8'h04;
         default: fixed_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign idx_inc  = (idx_q == 11'h7FF) ? idx_q : idx_q + 11'd1;
   assign oper_ok  = (oper_q == 16'h0001) || ((ACCEPT_REPLY != 0) && (oper_q == 16'h0002));
   // idx_q at the first dv-low cycle equals the number of bytes received
   assign frame_ok = !bad_q && (bcast_q || ucast_q) && oper_ok && (tpa_q == LOCAL_IP) &&
                     (32'(idx_q) >= 32'(MIN_LEN));

   // Next-state logic: per-byte field parsing and end-of-frame decision.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      bad_d         = bad_q;
      bcast_d       = bcast_q;
      ucast_d       = ucast_q;
      eth_hi_d      = eth_hi_q;
      src_d         = src_q;
      oper_d        = oper_q;
      sha_d         = sha_q;
      spa_d         = spa_q;
      tpa_d         = tpa_q;
      arp_valid_d   = 1'b0;
      arp_oper_d    = arp_oper_q;
      arp_sha_d     = arp_sha_q;
      arp_spa_d     = arp_spa_q;
      arp_src_mac_d = arp_src_mac_q;
      cnt_accept_d  = cnt_accept_q;
      cnt_drop_d    = cnt_drop_q;
      case (state_q)
         S_IDLE: begin
            // byte 0 of the dst MAC arrives together with the SFD pulse
            if (preamble_sfd_valid && mac_gmii_rx_dv) begin
               state_d = S_HDR;
               idx_d   = 11'd1;
               bad_d   = 1'b0;
               bcast_d = (mac_gmii_rxd == 8'hFF);
               ucast_d = (mac_gmii_rxd == mac_byte(3'd0));
            end
         end
         S_HDR: begin
            if (!mac_gmii_rx_dv) begin
               state_d = S_IDLE;             // ethertype unknown yet: not counted
            end else begin
               idx_d = idx_inc;
               if (mac_gmii_rx_er) bad_d = 1'b1;
               if (idx_q <= 11'd5) begin
                  bcast_d = bcast_q & (mac_gmii_rxd == 8'hFF);
                  ucast_d = ucast_q & (mac_gmii_rxd == mac_byte(idx_q[2:0]));
               end else if (idx_q <= 11'd11) begin
                  src_d = {src_q[39:0], mac_gmii_rxd};
               end else if (idx_q == 11'd12) begin
                  eth_hi_d = mac_gmii_rxd;
               end else begin
                  state_d = ({eth_hi_q, mac_gmii_rxd} == 16'h0806) ? S_ARP : S_IGN;
               end
            end
         end
         S_ARP: begin
            if (!mac_gmii_rx_dv) begin
               state_d    = S_IDLE;          // truncated ARP frame
               cnt_drop_d = sat_inc(cnt_drop_q);
            end else begin
               idx_d = idx_inc;
               if (mac_gmii_rx_er) bad_d = 1'b1;
               if (idx_q <= 11'd19) begin
                  if (mac_gmii_rxd != fixed_byte(idx_q)) bad_d = 1'b1;
               end else if (idx_q <= 11'd21) begin
                  oper_d = {oper_q[7:0], mac_gmii_rxd};
               end else if (idx_q <= 11'd27) begin
                  sha_d = {sha_q[39:0], mac_gmii_rxd};
               end else if (idx_q <= 11'd31) begin
                  spa_d = {spa_q[23:0], mac_gmii_rxd};
               end else if (idx_q >= 11'd38) begin
                  tpa_d = {tpa_q[23:0], mac_gmii_rxd};
                  if (idx_q == 11'd41) state_d = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            if (mac_gmii_rx_dv) begin
               idx_d = idx_inc;
               if (mac_gmii_rx_er) bad_d = 1'b1;
            end else begin
               state_d = S_IDLE;
               if (frame_ok) begin
                  arp_valid_d   = 1'b1;
                  arp_oper_d    = oper_q;
                  arp_sha_d     = sha_q;
                  arp_spa_d     = spa_q;
                  arp_src_mac_d = src_q;
                  cnt_accept_d  = sat_inc(cnt_accept_q);
               end else begin
                  cnt_drop_d = sat_inc(cnt_drop_q);
               end
            end
         end
         S_IGN: begin
            if (!mac_gmii_rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge mac_gmii_rx_clk) begin
      if (mac_gmii_rx_rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         bad_q         <= 1'b0;
         bcast_q       <= 1'b0;
         ucast_q       <= 1'b0;
         eth_hi_q      <= '0;
         src_q         <= '0;
         oper_q        <= '0;
         sha_q         <= '0;
         spa_q         <= '0;
         tpa_q         <= '0;
         arp_valid_q   <= 1'b0;
         arp_oper_q    <= '0;
         arp_sha_q     <= '0;
         arp_spa_q     <= '0;
         arp_src_mac_q <= '0;
         cnt_accept_q  <= '0;
         cnt_drop_q    <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         bad_q         <= bad_d;
         bcast_q       <= bcast_d;
         ucast_q       <= ucast_d;
         eth_hi_q      <= eth_hi_d;
         src_q         <= src_d;
         oper_q        <= oper_d;
         sha_q         <= sha_d;
         spa_q         <= spa_d;
         tpa_q         <= tpa_d;
         arp_valid_q   <= arp_valid_d;
         arp_oper_q    <= arp_oper_d;
         arp_sha_q     <= arp_sha_d;
         arp_spa_q     <= arp_spa_d;
         arp_src_mac_q <= arp_src_mac_d;
         cnt_accept_q  <= cnt_accept_d;
         cnt_drop_q    <= cnt_drop_d;
      end
   end

   assign arp_valid   = arp_valid_q;
   assign arp_oper    = arp_oper_q;
   assign arp_sha     = arp_sha_q;
   assign arp_spa     = arp_spa_q;
   assign arp_src_mac = arp_src_mac_q;
   assign cnt_accept  = cnt_accept_q;
   assign cnt_drop    = cnt_drop_q;

endmodule

// File: tb/tb_arp_parser_rx.sv
// Bench for arp_parser_rx: three instances (default, requests-only, 4-bit
// counters) share one byte stream; a frame-level model predicts each one.
module tb_arp_parser_rx;

   localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
   localparam logic [31:0] LIP   = 32'hC0_A8_01_0A;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rxd = 8'h00;
   logic dv = 1'b0, er = 1'b0, psv = 1'b0;

   logic        av0, av1, av2;
   logic [15:0] op0, op1, op2;
   logic [47:0] sha0, sha1, sha2, src0, src1, src2;
   logic [31:0] spa0, spa1, spa2;
   logic [15:0] ca0, cd0, ca1, cd1;
   logic [3:0]  ca2, cd2;

   always #4 clk = ~clk;

   arp_parser_rx dut0 (
      .mac_gmii_rx_clk(clk), .mac_gmii_rx_rst(rst), .mac_gmii_rxd(rxd),
      .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(psv),
      .arp_valid(av0), .arp_oper(op0), .arp_sha(sha0), .arp_spa(spa0),
      .arp_src_mac(src0), .cnt_accept(ca0), .cnt_drop(cd0));

   arp_parser_rx #(.ACCEPT_REPLY(0)) dut1 (
      .mac_gmii_rx_clk(clk), .mac_gmii_rx_rst(rst), .mac_gmii_rxd(rxd),
      .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(psv),
      .arp_valid(av1), .arp_oper(op1), .arp_sha(sha1), .arp_spa(spa1),
      .arp_src_mac(src1), .cnt_accept(ca1), .cnt_drop(cd1));

   arp_parser_rx #(.CNT_W(4)) dut2 (
      .mac_gmii_rx_clk(clk), .mac_gmii_rx_rst(rst), .mac_gmii_rxd(rxd),
      .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(psv),
      .arp_valid(av2), .arp_oper(op2), .arp_sha(sha2), .arp_spa(spa2),
      .arp_src_mac(src2), .cnt_accept(ca2), .cnt_drop(cd2));

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   // model state per instance
   bit          ar[3]     = '{1'b1, 1'b0, 1'b1};
   int          cmax[3]   = '{65535, 65535, 15};
   logic        e_valid[3];
   logic [15:0] e_oper[3];
   logic [47:0] e_sha[3], e_src[3];
   logic [31:0] e_spa[3];
   int          e_acc[3], e_drp[3];

   logic [7:0] frm[128];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         e_valid[k] = 1'b0; e_oper[k] = '0; e_sha[k] = '0; e_src[k] = '0;
         e_spa[k] = '0; e_acc[k] = 0; e_drp[k] = 0;
      end
   endtask

   // Frame outcome from the protocol rules: 0 no effect, 1 drop, 2 accept.
   function automatic int classify(input int n, input int er_at, input bit acc_rep);
      logic [47:0] d;
      logic [15:0] oper;
      logic [31:0] tpa;
      bit ok;
      if (n < 14) return 0;
      if ({frm[12], frm[13]} != 16'h0806) return 0;
      if (n < 42) return 1;
      d    = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      oper = {frm[20], frm[21]};
      tpa  = {frm[38], frm[39], frm[40], frm[41]};
      ok = (d == BCAST) || (d == LMAC);
      ok &= ({frm[14], frm[15], frm[16], frm[17], frm[18], frm[19]} == 48'h0001_0800_0604);
      ok &= (oper == 16'd1) || (acc_rep && oper == 16'd2);
      ok &= (tpa == LIP);
      ok &= !(er_at >= 1 && er_at < n);
      ok &= (n >= 64);
      return ok ? 2 : 1;
   endfunction

   task automatic model_eof(input int n, input int er_at);
      for (int k = 0; k < 3; k++) begin
         case (classify(n, er_at, ar[k]))
            2: begin
               e_valid[k] = 1'b1;
               e_oper[k]  = {frm[20], frm[21]};
               e_src[k]   = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
               e_sha[k]   = {frm[22], frm[23], frm[24], frm[25], frm[26], frm[27]};
               e_spa[k]   = {frm[28], frm[29], frm[30], frm[31]};
               if (e_acc[k] < cmax[k]) e_acc[k]++;
            end
            1: if (e_drp[k] < cmax[k]) e_drp[k]++;
            default: ;
         endcase
      end
   endtask

   task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] oper,
                        input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
      logic [47:0] src;
      src = {16'($urandom), 32'($urandom)};
      for (int i = 0; i < 128; i++) frm[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         frm[i]      = dst[47-8*i -: 8];
         frm[6+i]    = src[47-8*i -: 8];
         frm[22+i]   = sha[47-8*i -: 8];
      end
      frm[12] = et[15:8];   frm[13] = et[7:0];
      frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
      frm[18] = 8'h06; frm[19] = 8'h04;
      frm[20] = oper[15:8]; frm[21] = oper[7:0];
      for (int i = 0; i < 4; i++) begin
         frm[28+i] = spa[31-8*i -: 8];
         frm[38+i] = tpa[31-8*i -: 8];
      end
   endtask

   // Drive n bytes with dv high, then the end-of-frame gap.
   task automatic send(input int n, input int er_at);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         rxd = frm[i]; dv = 1'b1; er = (i == er_at); psv = (i == 0);
         @(posedge clk); #1;
      end
      rxd = 8'h00; dv = 1'b0; er = 1'b0; psv = 1'b0;
      @(posedge clk); #1;          // first dv-low cycle has been sampled
      model_eof(n, er_at);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) e_valid[k] = 1'b0;
      repeat (12) @(posedge clk);
   endtask

   task automatic chk_dut(input int k, input logic v, input logic [15:0] op, input logic [47:0] sh,
                          input logic [31:0] sp, input logic [47:0] sr, input logic [15:0] ca,
                          input logic [15:0] cd);
      check($sformatf("dut%0d.arp_valid", k), 64'(v), 64'(e_valid[k]));
      check($sformatf("dut%0d.arp_oper", k), 64'(op), 64'(e_oper[k]));
      check($sformatf("dut%0d.arp_sha", k), 64'(sh), 64'(e_sha[k]));
      check($sformatf("dut%0d.arp_spa", k), 64'(sp), 64'(e_spa[k]));
      check($sformatf("dut%0d.arp_src_mac", k), 64'(sr), 64'(e_src[k]));
      check($sformatf("dut%0d.cnt_accept", k), 64'(ca), 64'(e_acc[k]));
      check($sformatf("dut%0d.cnt_drop", k), 64'(cd), 64'(e_drp[k]));
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk_dut(0, av0, op0, sha0, spa0, src0, ca0, cd0);
         chk_dut(1, av1, op1, sha1, spa1, src1, ca1, cd1);
         chk_dut(2, av2, op2, sha2, spa2, src2, {12'd0, ca2}, {12'd0, cd2});
      end
   end

   initial begin
      int kind, n, er_at;
      logic [47:0] sha;
      logic [31:0] spa;
      model_reset();
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      // 1: broadcast request
      build(BCAST, 16'h0806, 16'h0001, 48'hAABBCCDDEE01, 32'hC0A80114, LIP);
      send(64, -1);
      check("t1.oper", 64'(op0), 64'h0001);
      check("t1.sha", 64'(sha0), 64'hAABBCCDDEE01);
      check("t1.spa", 64'(spa0), 64'hC0A80114);
      check("t1.cnt_accept", 64'(ca0), 64'd1);

      // 2: wrong TPA
      build(BCAST, 16'h0806, 16'h0001, 48'hAABBCCDDEE01, 32'hC0A80114, 32'hC0A8010B);
      send(64, -1);
      check("t2.cnt_drop", 64'(cd0), 64'd1);
      check("t2.sha_held", 64'(sha0), 64'hAABBCCDDEE01);

      // 3: unicast reply
      build(LMAC, 16'h0806, 16'h0002, 48'h112233445566, 32'hC0A80115, LIP);
      send(70, -1);
      check("t3.accept_reply1", 64'(ca0), 64'd2);
      check("t3.drop_reply0", 64'(cd1), 64'd2);

      // 4: rx_er at idx 30, then a 50-byte runt
      build(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80116, LIP);
      send(64, 30);
      send(50, -1);
      check("t4.cnt_drop", 64'(cd0), 64'd3);

      // 5: IPv4 frame, then ARP truncated at idx 25
      build(BCAST, 16'h0800, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80116, LIP);
      send(64, -1);
      build(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80116, LIP);
      send(25, -1);
      check("t5.cnt_drop", 64'(cd0), 64'd4);
      check("t5.cnt_accept", 64'(ca0), 64'd2);

      // 6: reset in the middle of a frame, then a good request
      build(BCAST, 16'h0806, 16'h0001, 48'hAABBCCDDEE02, 32'hC0A80117, LIP);
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
         rxd = frm[i]; dv = 1'b1; psv = (i == 0); rst = (i == 30 || i == 31);
         @(posedge clk); #1;
         if (i == 30) model_reset();
      end
      rxd = 8'h00; dv = 1'b0; psv = 1'b0; rst = 1'b0;
      repeat (14) @(posedge clk);
      check("t6.after_reset_acc", 64'(ca0), 64'd0);
      build(BCAST, 16'h0806, 16'h0001, 48'hAABBCCDDEE03, 32'hC0A80118, LIP);
      send(64, -1);
      check("t6.cnt_accept", 64'(ca0), 64'd1);
      check("t6.sha", 64'(sha0), 64'hAABBCCDDEE03);

      // randomized mix
      for (int t = 0; t < 40; t++) begin
         kind  = $urandom_range(0, 8);
         n     = $urandom_range(64, 90);
         er_at = -1;
         sha   = {16'($urandom), 32'($urandom)};
         spa   = $urandom;
         case (kind)
            0: build(BCAST, 16'h0806, 16'h0001, sha, spa, LIP);
            1: build(LMAC, 16'h0806, 16'h0002, sha, spa, LIP);
            2: build(BCAST, 16'h0806, 16'h0001, sha, spa, LIP ^ (32'd1 << $urandom_range(0, 31)));
            3: build(48'h02_00_00_00_00_02, 16'h0806, 16'h0001, sha, spa, LIP);
            4: begin
               build(BCAST, 16'h0806, 16'h0001, sha, spa, LIP);
               frm[14 + $urandom_range(0, 5)] ^= 8'h10;
            end
            5: begin
               build(LMAC, 16'h0806, 16'h0001, sha, spa, LIP);
               er_at = $urandom_range(1, n - 1);
            end
            6: begin
               build(BCAST, 16'h0806, 16'h0001, sha, spa, LIP);
               n = $urandom_range(42, 63);
            end
            7: begin
               build(BCAST, 16'h0806, 16'h0001, sha, spa, LIP);
               n = $urandom_range(1, 41);
            end
            default: build(BCAST, 16'h0800, 16'h0001, sha, spa, LIP);
         endcase
         send(n, er_at);
      end

      // enough good frames to saturate the 4-bit counter
      for (int t = 0; t < 20; t++) begin
         build(BCAST, 16'h0806, 16'h0001, {16'($urandom), 32'($urandom)}, $urandom, LIP);
         send(64 + t, -1);
      end
      check("sat.cnt_accept_w4", 64'(ca2), 64'hF);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
